// File: rtl/diff_and_clip_pkg.sv
// Shared types and constants for the strobed first-difference / saturation stage.
package diff_and_clip_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_e;

  localparam int unsigned CLIP_CNT_W = 16;

  // Largest positive two's-complement value for a w-bit sample.
  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative two's-complement value for a w-bit sample.
  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sub2_and_clip.sv
// Combinational saturating subtract: diff_c = sat(a_i - b_i), clip_c flags saturation.
module sub2_and_clip
  import diff_and_clip_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_c,
  output logic             clip_c
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] wide_c;

  assign wide_c = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};

  // The two top bits disagree exactly when the result leaves the WIDTH-bit range.
  always_comb begin
    clip_c = 1'b0;
    diff_c = wide_c[WIDTH-1:0];
    if (wide_c[WIDTH] != wide_c[WIDTH-1]) begin
      clip_c = 1'b1;
      diff_c = wide_c[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/diff_and_clip_reg.sv
// Strobed first-difference stage with saturation and decimation: y[n] = clip(x[n] - x[n-1]).
// Optional saturating clip counter output enabled by DIFF_AND_CLIP_COUNT_EN.
module diff_and_clip_reg
  import diff_and_clip_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              strobe_in,
  input  logic [RATE_W-1:0] rate,
  input  logic              clear,
  output logic [WIDTH-1:0]  diff,
  output logic              strobe_out,
  output logic              clipped,
  output logic              primed
`ifdef DIFF_AND_CLIP_COUNT_EN
  ,
  output logic [CLIP_CNT_W-1:0] clip_count
`endif
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              strobe_q, strobe_d;
  logic              clipped_q, clipped_d;

  logic [WIDTH-1:0]  sub_diff_c;
  logic              sub_clip_c;
  logic              keep_c;

  sub2_and_clip #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a_i    (in),
    .b_i    (prev_q),
    .diff_c (sub_diff_c),
    .clip_c (sub_clip_c)
  );

  // >= rather than == so a lowered rate never strands the counter above it.
  assign keep_c = (rate <= RATE_W'(1)) || (cnt_q >= (rate - RATE_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      prev_q    <= '0;
      cnt_q     <= '0;
      diff_q    <= '0;
      strobe_q  <= 1'b0;
      clipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      strobe_q  <= strobe_d;
      clipped_q <= clipped_d;
    end
  end

  // Next-state: clear beats strobe_in; only kept samples touch history and state.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    strobe_d  = 1'b0;
    clipped_d = clipped_q;

    if (clear) begin
      state_d = EMPTY;
      prev_d  = '0;
      cnt_d   = '0;
    end else if (strobe_in) begin
      if (keep_c) begin
        cnt_d  = '0;
        prev_d = in;
        case (state_q)
          EMPTY: begin
            state_d = PRIMED;
          end
          PRIMED: begin
            diff_d    = sub_diff_c;
            clipped_d = sub_clip_c;
            strobe_d  = 1'b1;
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end else begin
        cnt_d = cnt_q + RATE_W'(1);
      end
    end
  end

  assign diff       = diff_q;
  assign strobe_out = strobe_q;
  assign clipped    = clipped_q;
  assign primed     = (state_q == PRIMED);

`ifdef DIFF_AND_CLIP_COUNT_EN
  logic [CLIP_CNT_W-1:0] clip_count_q, clip_count_d;

  // Counts saturated outputs; moves in the same cycle strobe_out rises, sticks at all-ones.
  always_comb begin
    clip_count_d = clip_count_q;
    if (clear) begin
      clip_count_d = '0;
    end else if (strobe_d && clipped_d && (clip_count_q != '1)) begin
      clip_count_d = clip_count_q + CLIP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count_q <= '0;
    end else begin
      clip_count_q <= clip_count_d;
    end
  end

  assign clip_count = clip_count_q;
`else
  // No clip counter in this build.
`endif

endmodule

// File: tb/tb_diff_and_clip_reg.sv
// Directed table-driven bench for diff_and_clip_reg, plus short hand-written sequences.
module tb_diff_and_clip_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_s;
  logic        strobe_in;
  logic [7:0]  rate;
  logic        clear;
  logic [15:0] diff;
  logic        strobe_out;
  logic        clipped;
  logic        primed;
`ifdef DIFF_AND_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  diff_and_clip_reg #(
    .WIDTH  (16),
    .RATE_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_s),
    .strobe_in  (strobe_in),
    .rate       (rate),
    .clear      (clear),
    .diff       (diff),
    .strobe_out (strobe_out),
    .clipped    (clipped),
    .primed     (primed)
`ifdef DIFF_AND_CLIP_COUNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  typedef struct {
    bit rst;
    bit clr;
    bit stb;
    int in;
    int rate;
    bit e_stb;
    int e_diff;
    bit e_clip;
    bit e_primed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit c, bit s, int x, int rt,
                              bit es, int ed, bit ec, bit ep);
    vec_t v;
    v.rst = r; v.clr = c; v.stb = s; v.in = x; v.rate = rt;
    v.e_stb = es; v.e_diff = ed; v.e_clip = ec; v.e_primed = ep;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit s, input int x, input int rt);
    rst       = r;
    clear     = c;
    strobe_in = s;
    in_s      = 16'(x);
    rate      = 8'(rt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; clear = 1'b0; strobe_in = 1'b0; in_s = '0; rate = 8'd1;

    //                rst clr stb  in     rate  stb  diff    clip primed
    vecs.push_back(mk(1, 0, 0,      0, 1,   0,      0, 0, 0));  // 0 reset
    vecs.push_back(mk(0, 0, 1,    100, 1,   0,      0, 0, 1));  // 1 prime
    vecs.push_back(mk(0, 0, 1,    250, 1,   1,    150, 0, 1));
    vecs.push_back(mk(0, 0, 1,    200, 1,   1,    -50, 0, 1));
    vecs.push_back(mk(0, 0, 0,      0, 1,   0,    -50, 0, 1));  // 4 hold
    vecs.push_back(mk(1, 0, 0,      0, 1,   0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 1, -30000, 1,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,  30000, 1,   1,  32767, 1, 1));  // 7 clip max
    vecs.push_back(mk(0, 0, 1, -30000, 1,   1, -32768, 1, 1));  // 8 clip min
    vecs.push_back(mk(0, 0, 1, -30000, 1,   1,      0, 0, 1));  // 9 identical
    vecs.push_back(mk(0, 0, 1,     10, 1,   1,  30010, 0, 1));
    vecs.push_back(mk(0, 1, 1,     50, 1,   0,  30010, 0, 0));  // 11 clear beats strobe
    vecs.push_back(mk(0, 0, 1,     60, 1,   0,  30010, 0, 1));
    vecs.push_back(mk(0, 0, 1,     65, 1,   1,      5, 0, 1));
    vecs.push_back(mk(0, 0, 1,    100, 1,   1,     35, 0, 1));
    vecs.push_back(mk(1, 0, 0,      0, 1,   0,      0, 0, 0));  // 15 mid-stream reset
    vecs.push_back(mk(0, 0, 1,    300, 1,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,    310, 1,   1,     10, 0, 1));
    vecs.push_back(mk(1, 0, 0,      0, 4,   0,      0, 0, 0));  // 18 decimate by 4
    vecs.push_back(mk(0, 0, 1,      0, 4,   0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 1,      1, 4,   0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 1,      2, 4,   0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 1,      3, 4,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,      4, 4,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,      5, 4,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,      6, 4,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,      7, 4,   1,      4, 0, 1));
    vecs.push_back(mk(0, 0, 1,      8, 4,   0,      4, 0, 1));  // 27 counter -> 1
    vecs.push_back(mk(0, 0, 1,      9, 4,   0,      4, 0, 1));  // counter -> 2
    vecs.push_back(mk(0, 0, 1,     10, 2,   1,      3, 0, 1));  // 29 rate lowered
    vecs.push_back(mk(0, 0, 1,     11, 2,   0,      3, 0, 1));
    vecs.push_back(mk(0, 0, 1,     12, 2,   1,      2, 0, 1));
    vecs.push_back(mk(0, 0, 1,     20, 0,   1,      8, 0, 1));  // 32 rate 0 keeps all
    vecs.push_back(mk(0, 0, 1,     20, 0,   1,      0, 0, 1));
    vecs.push_back(mk(0, 0, 0,      0, 1,   0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 1,  32767, 1,   1,  32747, 0, 1));
    vecs.push_back(mk(0, 0, 1, -32768, 1,   1, -32768, 1, 1));  // 36 extreme min
    vecs.push_back(mk(0, 1, 0,      0, 1,   0, -32768, 1, 0));  // 37 clear holds diff
    vecs.push_back(mk(0, 0, 1,      5, 1,   0, -32768, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].stb, vecs[i].in, vecs[i].rate);
      check($sformatf("row%0d strobe_out", i), int'(strobe_out), int'(vecs[i].e_stb));
      check($sformatf("row%0d diff", i), int'($signed(diff)), vecs[i].e_diff);
      check($sformatf("row%0d clipped", i), int'(clipped), int'(vecs[i].e_clip));
      check($sformatf("row%0d primed", i), int'(primed), int'(vecs[i].e_primed));
    end

    // One kept sample must give exactly one strobe_out pulse.
    pulses = 0;
    drive(0, 0, 1, 9, 1);
    if (strobe_out) pulses++;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1);
      if (strobe_out) pulses++;
    end
    check("single_pulse_count", pulses, 1);
    check("single_pulse_diff", int'($signed(diff)), 4);

`ifdef DIFF_AND_CLIP_COUNT_EN
    drive(1, 0, 0, 0, 1);
    check("clip_count_reset", int'(clip_count), 0);
    drive(0, 0, 1, -30000, 1);
    drive(0, 0, 1,  30000, 1);
    drive(0, 0, 1, -30000, 1);
    drive(0, 0, 1,  30000, 1);
    drive(0, 0, 1,  30001, 1);
    drive(0, 0, 1,  30001, 1);
    check("clip_count_three", int'(clip_count), 3);
    drive(0, 1, 0, 0, 1);
    check("clip_count_clear", int'(clip_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
